// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS debug path: dumper FSM states and sizing helpers.
package mips_debug_pkg;

  localparam int DEFAULT_NBITS     = 32;
  localparam int DEFAULT_BYTE_BITS = 8;
  localparam int DEFAULT_ADDR_STEP = 4;
  localparam int BYTES_PER_WORD    = DEFAULT_NBITS / DEFAULT_BYTE_BITS;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_LOAD    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5,
    ST_NEXT    = 3'd6,
    ST_DONE    = 3'd7
  } dump_state_e;

  // Counter width that stays legal when only a single value is needed.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_debug_word_serializer.sv
// Holds one memory word and presents it MSB byte first, shifting one byte per request.
module mem_debug_word_serializer
  import mips_debug_pkg::*;
#(
  parameter int NBITS     = DEFAULT_NBITS,
  parameter int BYTE_BITS = DEFAULT_BYTE_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [NBITS-1:0]     i_word,
  output logic [BYTE_BITS-1:0] o_top_byte,
  output logic                 o_last_byte
);

  localparam int NBYTES = NBITS / BYTE_BITS;
  localparam int CW     = cnt_width(NBYTES);

  logic [NBITS-1:0] shift_reg;
  logic [CW-1:0]    byte_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (i_load) begin
      shift_reg <= i_word;
      byte_cnt  <= '0;
    end else if (i_shift) begin
      shift_reg <= shift_reg << BYTE_BITS;
      byte_cnt  <= byte_cnt + 1'b1;
    end
  end

  assign o_top_byte  = shift_reg[NBITS-1 -: BYTE_BITS];
  assign o_last_byte = (byte_cnt == CW'(NBYTES - 1));

endmodule

// File: rtl/mem_debug_dumper.sv
// Walks TAM_M data-memory words through the debug read port and streams them to the UART TX bytewise.
module mem_debug_dumper
  import mips_debug_pkg::*;
#(
  parameter int NBITS     = DEFAULT_NBITS,
  parameter int TAM_M     = 10,
  parameter int ADDR_STEP = DEFAULT_ADDR_STEP,
  parameter int BYTE_BITS = DEFAULT_BYTE_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic [NBITS-1:0]     o_mem_debug_addr,
  input  logic [NBITS-1:0]     i_mem_debug_data,
  output logic [BYTE_BITS-1:0] o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int WC = cnt_width(TAM_M);

  dump_state_e      state_q, state_d;
  logic [NBITS-1:0] addr_q;
  logic [WC-1:0]    word_cnt;
  logic             load_word, shift_byte, addr_clr, addr_inc, last_byte;

  mem_debug_word_serializer #(
    .NBITS     (NBITS),
    .BYTE_BITS (BYTE_BITS)
  ) u_serializer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (load_word),
    .i_shift     (shift_byte),
    .i_word      (i_mem_debug_data),
    .o_top_byte  (o_tx_data),
    .o_last_byte (last_byte)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ADDR and WAIT give the one-cycle-latency debug port time to return the word before LOAD.
  always_comb begin
    state_d    = state_q;
    load_word  = 1'b0;
    shift_byte = 1'b0;
    addr_clr   = 1'b0;
    addr_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_clr = 1'b1;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_LOAD;
      ST_LOAD: begin
        load_word = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (last_byte) begin
            state_d = ST_NEXT;
          end else begin
            shift_byte = 1'b1;
            state_d    = ST_SEND;
          end
        end
      end
      ST_NEXT: begin
        if (word_cnt == WC'(TAM_M - 1)) begin
          state_d = ST_DONE;
        end else begin
          addr_inc = 1'b1;
          state_d  = ST_ADDR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      addr_q   <= '0;
      word_cnt <= '0;
    end else if (addr_clr) begin
      addr_q   <= '0;
      word_cnt <= '0;
    end else if (addr_inc) begin
      addr_q   <= addr_q + NBITS'(ADDR_STEP);
      word_cnt <= word_cnt + 1'b1;
    end
  end

  assign o_mem_debug_addr = addr_q;
  assign o_tx_start       = (state_q == ST_SEND);
  assign o_done           = (state_q == ST_DONE);
  assign o_busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Self-checking bench: three dumper instances (TAM_M = 2, 1, 10) driven by a memory and UART TX model.
module tb_mem_debug_dumper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s   [3];
  logic        tx_done_s [3];
  logic [31:0] mem_addr  [3];
  logic [7:0]  tx_data   [3];
  logic        tx_start  [3];
  logic        busy      [3];
  logic        done      [3];
  logic [31:0] mem       [3][16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] rdata;

    always @(posedge clk) rdata <= mem[g][mem_addr[g][5:2]];

    mem_debug_dumper #(
      .NBITS     (32),
      .TAM_M     ((g == 0) ? 2 : ((g == 1) ? 1 : 10)),
      .ADDR_STEP (4),
      .BYTE_BITS (8)
    ) u_dut (
      .i_clk            (clk),
      .i_reset          (rst_n),
      .i_start          (start_s[g]),
      .o_mem_debug_addr (mem_addr[g]),
      .i_mem_debug_data (rdata),
      .o_tx_data        (tx_data[g]),
      .o_tx_start       (tx_start[g]),
      .i_tx_done        (tx_done_s[g]),
      .o_busy           (busy[g]),
      .o_done           (done[g])
    );
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input int k, input string tag);
    check_output({tag, "_addr"},  mem_addr[k], 32'h0);
    check_output({tag, "_data"},  32'(tx_data[k]), 32'h0);
    check_output({tag, "_start"}, 32'(tx_start[k]), 32'h0);
    check_output({tag, "_busy"},  32'(busy[k]), 32'h0);
    check_output({tag, "_done"},  32'(done[k]), 32'h0);
  endtask

  // Reference: the dump is every word of the range, MSB byte first, one byte per TX handshake.
  task automatic run_dump(input int k, input int tam, input int delay,
                          input bit extra_start, input bit spurious, input bit mid_reset);
    logic [7:0] exp_q [$];
    logic [7:0] hold;
    int got, cnt, cycles;
    bit finished;
    hold = '0; got = 0; cnt = 0; cycles = 0; finished = 1'b0;
    for (int w = 0; w < tam; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'(mem[k][w] >> (24 - 8 * b)));

    start_s[k]   = 1'b1;
    tx_done_s[k] = spurious;
    @(posedge clk); #1;
    cycles       = 1;
    start_s[k]   = 1'b0;
    tx_done_s[k] = 1'b0;
    check_output("busy_after_start", 32'(busy[k]), 32'h1);
    check_output("addr_first", mem_addr[k], 32'h0);

    while (!finished && cycles < 2000) begin
      start_s[k]   = 1'b0;
      tx_done_s[k] = 1'b0;
      if (done[k]) begin
        finished = 1'b1;
        check_output("done_byte_count", 32'(got), 32'(exp_q.size()));
        check_output("last_addr", mem_addr[k], 32'(4 * (tam - 1)));
        check_output("busy_in_done", 32'(busy[k]), 32'h0);
      end else begin
        check_output("busy_during_dump", 32'(busy[k]), 32'h1);
        if (tx_start[k]) begin
          check_output("byte_in_range", 32'(got < exp_q.size()), 32'h1);
          if (got < exp_q.size()) check_output("tx_byte", 32'(tx_data[k]), 32'(exp_q[got]));
          check_output("tx_addr", mem_addr[k], 32'(4 * (got / 4)));
          if (got == 0) check_output("first_start_latency", 32'(cycles), 32'd4);
          hold = tx_data[k];
          cnt  = delay;
          got++;
          if (spurious) tx_done_s[k] = 1'b1;
          if (extra_start && got == 2) start_s[k] = 1'b1;
          if (mid_reset && got == 3) begin
            #3 rst_n = 1'b0;
            #1 check_quiet(k, "mid_reset");
            @(posedge clk); #3 rst_n = 1'b1;
            @(posedge clk); #1;
            return;
          end
        end else if (cnt > 0) begin
          check_output("tx_data_hold", 32'(tx_data[k]), 32'(hold));
          cnt--;
          if (cnt == 0) tx_done_s[k] = 1'b1;
        end
      end
      @(posedge clk); #1;
      cycles++;
    end

    start_s[k]   = 1'b0;
    tx_done_s[k] = 1'b0;
    check_output("dump_finished", 32'(finished), 32'h1);
    repeat (3) begin
      @(posedge clk); #1;
      check_output("after_busy",  32'(busy[k]), 32'h0);
      check_output("after_done",  32'(done[k]), 32'h0);
      check_output("after_start", 32'(tx_start[k]), 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i]   = 1'b0;
      tx_done_s[i] = 1'b0;
      for (int j = 0; j < 16; j++) mem[i][j] = 32'h0;
    end
    mem[0][0] = 32'h11223344;
    mem[0][1] = 32'hAABBCCDD;
    mem[1][0] = 32'hDEADBEEF;
    for (int j = 0; j < 10; j++) mem[2][j] = $urandom;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_quiet(i, "reset");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic two-word dump");
    run_dump(0, 2, 5, 1'b0, 1'b0, 1'b0);

    $display("[TB] start pulsed while busy");
    run_dump(0, 2, 5, 1'b1, 1'b0, 1'b0);

    $display("[TB] spurious tx_done in IDLE and SEND");
    tx_done_s[0] = 1'b1;
    @(posedge clk); #1;
    tx_done_s[0] = 1'b0;
    check_output("idle_done_ignored_busy", 32'(busy[0]), 32'h0);
    check_output("idle_done_ignored_start", 32'(tx_start[0]), 32'h0);
    run_dump(0, 2, 3, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset in the middle of a dump");
    run_dump(0, 2, 2, 1'b0, 1'b0, 1'b1);
    run_dump(0, 2, 5, 1'b0, 1'b0, 1'b0);

    $display("[TB] single-word dump");
    run_dump(1, 1, 5, 1'b0, 1'b0, 1'b0);

    $display("[TB] full ten-word dump");
    run_dump(2, 10, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized words and TX latency");
    mem[0][0] = $urandom;
    mem[0][1] = $urandom;
    run_dump(0, 2, int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) mem[2][j] = $urandom;
    run_dump(2, 10, int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_debug_dumper.md
Name: mem_debug_dumper

Overview:
- Debug-side reader for the data memory in the MEM stage. On command, it walks a range of data-memory words through the memory's debug address/data port.
- Each 32-bit word is split into bytes and handed one at a time to the UART transmitter using a start/done handshake.
- Sits between the debug unit (command source), the MEM stage debug read port, and the UART TX.

Parameters:
- NBITS, 32, data word width; must be a multiple of 8.
- TAM_M, 10, number of words dumped per command.
- ADDR_STEP, 4, byte-address increment between consecutive words.
- BYTE_BITS, 8, width of one transmitted byte.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle dump request from the debug unit.
- o_mem_debug_addr  out  NBITS  byte address driven to the memory debug port.
- i_mem_debug_data  in  NBITS  word returned by the memory debug port.
- o_tx_data  out  BYTE_BITS  byte presented to the UART TX.
- o_tx_start  out  1  one-cycle pulse; o_tx_data is valid that cycle.
- i_tx_done  in  1  one-cycle pulse from the UART TX when the byte has been sent.
- o_busy  out  1  high from the cycle after i_start is accepted until the cycle DONE is entered.
- o_done  out  1  one-cycle pulse after the last byte's i_tx_done.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all outputs 0; address, word and byte counters 0; shift register 0.
- The memory debug port has 1-cycle read latency: data for o_mem_debug_addr is valid on i_mem_debug_data on the following clock edge.
- FSM states: IDLE, ADDR, WAIT, LOAD, SEND, WAIT_TX, NEXT, DONE.
- IDLE: on i_start=1, go to ADDR; o_mem_debug_addr=0, word_cnt=0.
- ADDR: address is stable; go to WAIT.
- WAIT: go to LOAD.
- LOAD: capture i_mem_debug_data into the shift register; byte_cnt=0; go to SEND.
- SEND: o_tx_data = shift[NBITS-1 -: 8] (MSB byte first); o_tx_start=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: hold o_tx_data stable. On i_tx_done:
  - if byte_cnt < NBITS/8-1: shift left 8, byte_cnt+1, go to SEND;
  - otherwise go to NEXT.
- NEXT:
  - if word_cnt == TAM_M-1, go to DONE;
  - otherwise word_cnt+1, o_mem_debug_addr += ADDR_STEP, go to ADDR.
- DONE: o_done=1 for one cycle; go to IDLE.
- o_busy=1 in ADDR through NEXT, 0 in IDLE and DONE.
- i_start while not in IDLE is ignored; no queuing.
- i_tx_done outside WAIT_TX is ignored.
- i_tx_done arriving on the same cycle as o_tx_start is not counted; only WAIT_TX samples it.
- Address arithmetic is NBITS-wide unsigned and wraps modulo 2^NBITS; no error flag.
- i_start and i_tx_done in the same cycle while in IDLE: i_start is accepted, i_tx_done is ignored.
- Reset asserted mid-dump: immediate return to IDLE, outputs 0, no o_done; the next i_start restarts from address 0.
- TAM_M=1: exactly NBITS/8 bytes are sent, then o_done.
- Total bytes per dump = TAM_M*NBITS/8. Latency from i_start to the first o_tx_start is 4 cycles.

Decomposition:
- Shared package mips_debug_pkg holds:
  - FSM state encodings (3-bit localparams);
  - BYTES_PER_WORD = NBITS/BYTE_BITS;
  - the default ADDR_STEP.
- One sub-module: mem_debug_word_serializer.
  - Behaviour: load, shift left by BYTE_BITS, byte counter, last_byte flag.
  - The top level keeps the FSM, the address/word counter and the handshake.

Test Plan:
- Reset, then i_start with memory words [0]=0x11223344 and [1]=0xAABBCCDD, TAM_M=2, TX model answering i_tx_done 5 cycles after each start -> bytes 11,22,33,44,AA,BB,CC,DD in order; addresses 0 then 4; one o_done pulse; o_busy low afterwards.
- i_start pulsed again while o_busy=1 -> ignored; byte count stays TAM_M*4 and there is exactly one o_done.
- Spurious i_tx_done in IDLE and in SEND -> no byte skipped; o_tx_data stable during WAIT_TX until the real done.
- i_reset driven low after the 3rd byte, asynchronously between edges -> outputs 0 immediately; after release, a new i_start sends 0x11 first from address 0.
- TAM_M=1, word 0xDEADBEEF -> exactly DE,AD,BE,EF, then o_done; first o_tx_start 4 cycles after i_start.
- TAM_M=10 full dump with the TX done returned immediately the cycle after start -> 40 bytes; last address 36 (0x24).
